// File: rtl/period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : period_meter_pkg
// Description : Shared types, default widths and helper function for the
//               period meter and its edge synchronizer.
//               The optional debounce filter is enabled by defining
//               PERIOD_METER_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package period_meter_pkg;

    // Measurement FSM: IDLE waits for a reference edge, MEASURE counts.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam int c_DEF_CLOCK_FREQ_HZ   = 50_000_000;
    localparam int c_DEF_TIMEOUT_MS      = 2000;
    localparam int c_DEF_COUNT_WIDTH     = 32;
    localparam int c_DEF_MS_WIDTH        = 16;
    localparam int c_DEF_DEBOUNCE_CYCLES = 4;

    // Clock cycles in one millisecond.
    function automatic int cycles_per_ms(input int freq);
        return freq / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/period_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : period_meter_if
// Description : Bundles the measured wave input and the measurement results.
//               master : wave source / result consumer
//               slave  : the period meter itself
// Signals     : wave_in        - asynchronous square wave
//               period_cycles  - last period in clock cycles
//               period_ms      - last period in whole milliseconds
//               measure_valid  - one-cycle result strobe
//               locked         - a valid measurement exists
//               timeout        - sticky no-edge flag
// Revision    : 1.0 - initial release
// ============================================================================
interface period_meter_if
    import period_meter_pkg::*;
#(
    parameter int COUNT_WIDTH = c_DEF_COUNT_WIDTH,
    parameter int MS_WIDTH    = c_DEF_MS_WIDTH
);
    logic                   wave_in;
    logic [COUNT_WIDTH-1:0] period_cycles;
    logic [MS_WIDTH-1:0]    period_ms;
    logic                   measure_valid;
    logic                   locked;
    logic                   timeout;

    modport master (
        output wave_in,
        input  period_cycles,
        input  period_ms,
        input  measure_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  wave_in,
        output period_cycles,
        output period_ms,
        output measure_valid,
        output locked,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/period_meter_edge_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : edge_synchronizer
// Description : Two-flop synchronizer, optional debounce filter and a prev
//               register producing a one-cycle rising-edge pulse.
//               Define PERIOD_METER_DEBOUNCE_EN to insert the filter; the
//               filtered level then follows the synchronized level only after
//               it has differed for DEBOUNCE_CYCLES consecutive cycles.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               i_async   - asynchronous input level
//               o_rise    - one-cycle pulse on a (filtered) rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module edge_synchronizer
    import period_meter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_rise
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("edge_synchronizer: DEBOUNCE_CYCLES must be at least 1");
    end

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PERIOD_METER_DEBOUNCE_EN
    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic              r_filt;
    logic [c_DB_W-1:0] r_db_cnt;

    // The counter tracks how long the raw level has disagreed with the
    // filtered one; any agreement restarts the count, so short glitches die.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt   <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 != r_filt) begin
            if (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_filt   <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module      : period_meter
// Description : Measures the period of an external square wave between
//               consecutive rising edges, in clock cycles and whole ms.
//               Optional debounce filter: define PERIOD_METER_DEBOUNCE_EN.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus       - period_meter_if.slave (wave_in in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ   = c_DEF_CLOCK_FREQ_HZ,
    parameter int TIMEOUT_MS      = c_DEF_TIMEOUT_MS,
    parameter int COUNT_WIDTH     = c_DEF_COUNT_WIDTH,
    parameter int MS_WIDTH        = c_DEF_MS_WIDTH,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  wire logic     clk,
    input  wire logic     rst,
    period_meter_if.slave bus
);

    localparam int                     c_CYCLES_PER_MS = cycles_per_ms(CLOCK_FREQ_HZ);
    localparam logic [COUNT_WIDTH-1:0] c_SUB_LAST      = COUNT_WIDTH'(c_CYCLES_PER_MS - 1);
    localparam logic [MS_WIDTH-1:0]    c_TIMEOUT       = MS_WIDTH'(TIMEOUT_MS);

    if (c_CYCLES_PER_MS < 2) begin : g_bad_freq
        $error("period_meter: CLOCK_FREQ_HZ must give at least 2 cycles per ms");
    end

    logic w_edge;

    edge_synchronizer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.wave_in),
        .o_rise  (w_edge)
    );

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] r_ms_sub;
    logic [MS_WIDTH-1:0]    r_ms_cnt;
    logic [COUNT_WIDTH-1:0] r_period_cycles;
    logic [MS_WIDTH-1:0]    r_period_ms;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_timeout;
    logic                   w_capture;
    logic                   w_expire;
    logic                   w_count;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // An edge coinciding with the limit wins over the timeout.
                if (!w_edge && (r_ms_cnt == c_TIMEOUT)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_expire  = 1'b0;
        w_count   = 1'b0;
        if (r_state == ST_MEASURE) begin
            w_capture = w_edge;
            w_expire  = !w_edge && (r_ms_cnt == c_TIMEOUT);
            w_count   = !w_edge;
        end
    end

    // ---------------------------------------------------------------- counters
    // cnt == ms_cnt*CYCLES_PER_MS + ms_sub, so the ms result needs no divider.
    // Reload to 1 on an edge: the edge cycle itself is the first counted cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_ms_sub <= '0;
            r_ms_cnt <= '0;
        end else if (w_edge) begin
            r_cnt    <= COUNT_WIDTH'(1);
            r_ms_sub <= COUNT_WIDTH'(1);
            r_ms_cnt <= '0;
        end else if (w_count) begin
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_ms_sub == c_SUB_LAST) begin
                r_ms_sub <= '0;
                if (r_ms_cnt != '1) begin
                    r_ms_cnt <= r_ms_cnt + 1'b1;
                end
            end else begin
                r_ms_sub <= r_ms_sub + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cycles <= '0;
            r_period_ms     <= '0;
            r_valid         <= 1'b0;
            r_locked        <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_period_cycles <= r_cnt;
                r_period_ms     <= r_ms_cnt;
                r_locked        <= 1'b1;
            end
            // Timeout is sticky until any edge is seen again.
            if (w_edge) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
                r_locked  <= 1'b0;
            end
        end
    end

    assign bus.period_cycles = r_period_cycles;
    assign bus.period_ms     = r_period_ms;
    assign bus.measure_valid = r_valid;
    assign bus.locked        = r_locked;
    assign bus.timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_period_meter
// Description : Self-checking bench for period_meter (10 cycles per ms,
//               20 ms timeout). Directed vector table plus hand sequences for
//               reset, timeout, re-lock and mid-period reset.
//               Define PERIOD_METER_DEBOUNCE_EN to exercise the filter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_period_meter;

    localparam int CLK_HZ = 10_000;
    localparam int TO_MS  = 20;
    localparam int CW     = 32;
    localparam int MW     = 16;
    localparam int DB     = 4;
    localparam int NVEC   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    period_meter_if #(.COUNT_WIDTH(CW), .MS_WIDTH(MW)) bus ();

    period_meter #(
        .CLOCK_FREQ_HZ   (CLK_HZ),
        .TIMEOUT_MS      (TO_MS),
        .COUNT_WIDTH     (CW),
        .MS_WIDTH        (MW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [CW-1:0] pc;
        logic [MW-1:0] pm;
        logic        lk;
        logic        to;
    } meas_t;

    typedef struct {
        int period;
        int exp_pc;
        int exp_pm;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    meas_t q[$];
    vec_t  vt[NVEC];

    // Result monitor: samples 1 ns after each rising clock edge.
    initial begin
        meas_t m;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.measure_valid === 1'b1) begin
                m.cyc = cyc;
                m.pc  = bus.period_cycles;
                m.pm  = bus.period_ms;
                m.lk  = bus.locked;
                m.to  = bus.timeout;
                q.push_back(m);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wave_period(input int p);
        bus.wave_in = 1'b1;
        tick(p / 2);
        bus.wave_in = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"},    64'(bus.period_cycles), 64'd0);
        chk({tag, "_pm"},    64'(bus.period_ms),     64'd0);
        chk({tag, "_valid"}, 64'(bus.measure_valid), 64'd0);
        chk({tag, "_lock"},  64'(bus.locked),        64'd0);
        chk({tag, "_tmo"},   64'(bus.timeout),       64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v_last;
        int target;

        vt[0] = '{50, 50, 5};
        vt[1] = '{50, 50, 5};
        vt[2] = '{50, 50, 5};
        vt[3] = '{57, 57, 5};
        vt[4] = '{10, 10, 1};
`ifdef PERIOD_METER_DEBOUNCE_EN
        vt[5] = '{12, 12, 1};
        vt[6] = '{13, 13, 1};
`else
        vt[5] = '{2, 2, 0};
        vt[6] = '{3, 3, 0};
`endif
        vt[7] = '{200, 200, 20};   // edge lands exactly on the timeout limit
        vt[8] = '{199, 199, 19};
        vt[9] = '{50, 50, 5};

        // ---------------- reset values, single edge only arms
        bus.wave_in = 1'b0;
        rst = 1'b1;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(2);
        q.delete();
        bus.wave_in = 1'b1;
        tick(60);
        chk("single_edge_nvalid", 64'(q.size()), 64'd0);
        chk("single_edge_lock",   64'(bus.locked), 64'd0);
        bus.wave_in = 1'b0;
        tick(10);

        // ---------------- table of periods
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        q.delete();
        for (int i = 0; i < NVEC; i++) begin
            wave_period(vt[i].period);
        end
        bus.wave_in = 1'b1;         // closing edge of the last period
        tick(25);
        bus.wave_in = 1'b0;
        chk("vec_count", 64'(q.size()), 64'(NVEC));
        for (int i = 0; i < NVEC; i++) begin
            if (i < q.size()) begin
                chk($sformatf("vec%0d_pc", i),   64'(q[i].pc), 64'(vt[i].exp_pc));
                chk($sformatf("vec%0d_pm", i),   64'(q[i].pm), 64'(vt[i].exp_pm));
                chk($sformatf("vec%0d_lock", i), 64'(q[i].lk), 64'd1);
                chk($sformatf("vec%0d_tmo", i),  64'(q[i].to), 64'd0);
                if (i > 0) begin
                    chk($sformatf("vec%0d_spacing", i), 64'(q[i].cyc - q[i-1].cyc),
                        64'(vt[i].period));
                end
            end
        end

        // ---------------- wave stops low: timeout 200 cycles after last edge
        v_last = (q.size() > 0) ? q[q.size()-1].cyc : cyc;
        target = v_last + 10 * TO_MS - 1;
        for (int k = 0; k < 1000 && cyc < target; k++) tick(1);
        chk("pre_tmo_lock", 64'(bus.locked),  64'd1);
        chk("pre_tmo_flag", 64'(bus.timeout), 64'd0);
        tick(1);
        chk("tmo_lock", 64'(bus.locked),        64'd0);
        chk("tmo_flag", 64'(bus.timeout),       64'd1);
        chk("tmo_pc",   64'(bus.period_cycles), 64'd50);
        chk("tmo_pm",   64'(bus.period_ms),     64'd5);
        tick(30);
        chk("tmo_sticky",  64'(bus.timeout), 64'd1);
        chk("held_low_nvalid", 64'(q.size()), 64'(NVEC));

        // ---------------- re-lock with two edges 40 cycles apart
        bus.wave_in = 1'b1;
        tick(20);
        chk("rearm_lock",   64'(bus.locked), 64'd0);
        chk("rearm_nvalid", 64'(q.size()),   64'(NVEC));
        bus.wave_in = 1'b0;
        tick(20);
        bus.wave_in = 1'b1;
        tick(20);
        bus.wave_in = 1'b0;
        tick(5);
        chk("relock_count", 64'(q.size()), 64'(NVEC + 1));
        if (q.size() > NVEC) begin
            chk("relock_pc",   64'(q[NVEC].pc), 64'd40);
            chk("relock_pm",   64'(q[NVEC].pm), 64'd4);
            chk("relock_lock", 64'(q[NVEC].lk), 64'd1);
            chk("relock_tmo",  64'(q[NVEC].to), 64'd0);
        end

        // ---------------- reset in the low phase of a running wave
        tick(15);
        for (int i = 0; i < 3; i++) wave_period(30);
        bus.wave_in = 1'b1;
        tick(15);
        bus.wave_in = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(2);
        chk_all_zero("midrst");
        rst = 1'b0;
        q.delete();
        tick(8);
        wave_period(30);            // arms only
`ifdef PERIOD_METER_DEBOUNCE_EN
        bus.wave_in = 1'b1;         // period containing a 2-cycle glitch
        tick(15);
        bus.wave_in = 1'b0;
        tick(5);
        bus.wave_in = 1'b1;
        tick(2);
        bus.wave_in = 1'b0;
        tick(8);
`else
        wave_period(30);
`endif
        wave_period(30);
        bus.wave_in = 1'b1;
        tick(15);
        bus.wave_in = 1'b0;
        tick(5);
        chk("postrst_count", 64'(q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) begin
                chk($sformatf("postrst%0d_pc", i), 64'(q[i].pc), 64'd30);
                chk($sformatf("postrst%0d_pm", i), 64'(q[i].pm), 64'd3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
